instr_fetch: RTL and testbench

Instruction fetch unit for the picoMIPS core. It sits between the program counter and the decoder. It takes the current PC address, issues synchronous reads to the program ROM, and drives the PC's increment strobe back to the PC. Returned instruction words go into a small show-ahead queue and are handed to the decoder over a valid/ready handshake. A branch flush discards all fetched and in-flight words.

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: picoMIPS instruction fetch unit.
// Issues one synchronous ROM read per cycle whenever the show-ahead queue
// has room for it, including the word already in flight. Each read returns
// one cycle later with its tag (the fetch address) and is queued for the
// decoder. A flush or reset discards queued and in-flight words.
// Optional feature: define IFETCH_BYPASS_EN to let a returning word drive
// the outputs directly when the queue is empty, which cuts the issue-to-valid
// latency from 2 cycles to 1.
module instr_fetch #(
    parameter int Psize = 6,
    parameter int Isize = 20,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Psize-1:0] pc_addr,
    output logic             pc_incr,
    output logic             mem_en,
    output logic [Psize-1:0] mem_addr,
    input  logic [Isize-1:0] mem_rdata,
    input  logic             flush,
    output logic [Isize-1:0] instr,
    output logic [Psize-1:0] instr_addr,
    output logic             instr_valid,
    input  logic             instr_ready
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    // Return stage: vld_p1 marks an unkilled read issued last cycle,
    // tag_p1 holds the address it was issued for.
    logic             vld_p1;
    logic [Psize-1:0] tag_p1;

    // Queue state; storage is data only and is never reset.
    logic [CW-1:0]    count;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [Isize-1:0] q_instr [Depth];
    logic [Psize-1:0] q_addr  [Depth];

    logic             byp;
    logic             pop;
    logic             push;
    logic             q_push;
    logic             q_pop;
    logic             issue;
    logic [CW-1:0]    occ;

    // Head selection: bypassed return, queue head, or zero when empty.
    always_comb begin
        byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
        byp = (count == '0) && vld_p1;
`endif
        instr_valid = (count != '0) || byp;
        if (byp) begin
            instr      = mem_rdata;
            instr_addr = tag_p1;
        end else if (count != '0) begin
            instr      = q_instr[rptr];
            instr_addr = q_addr[rptr];
        end else begin
            instr      = '0;
            instr_addr = '0;
        end
    end

    // Handshake, queue push/pop and the issue decision.
    always_comb begin
        pop    = instr_valid && instr_ready;
        push   = vld_p1 && reset && !flush;
        // A bypassed word that the decoder takes right away never enters the queue.
        q_push = push && !(byp && pop);
        q_pop  = pop && (count != '0) && reset && !flush;
        // Occupancy as it will stand once the in-flight word lands and the pop retires.
        occ    = count + CW'(vld_p1) - CW'(pop);
        issue  = reset && !flush && (occ < CW'(Depth));
        mem_en   = issue;
        pc_incr  = issue;
        mem_addr = pc_addr;
    end

    // Issue -> return boundary: remember whether a read is in flight and its address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            tag_p1 <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                tag_p1 <= pc_addr;
            end
        end
    end

    // Queue control: occupancy and wrapping pointers, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (q_push) begin
                wptr <= wptr + AW'(1);
            end
            if (q_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(q_push) - CW'(q_pop);
        end
    end

    // Return -> queue boundary: write the returned word and its tag at the tail.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_instr[wptr] <= mem_rdata;
            q_addr[wptr]  <= tag_p1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: bench for instr_fetch with a PC model, a synchronous ROM
// holding ROM[a] = a + 0x100, and a reference model that tracks issued
// addresses as a list of (address, issue cycle) pairs.
module tb_instr_fetch;

    localparam int PS    = 6;
    localparam int IS    = 20;
    localparam int DEPTH = 2;
`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk;
    logic          reset;
    logic [PS-1:0] pc;
    logic          pc_incr;
    logic          mem_en;
    logic [PS-1:0] mem_addr;
    logic [IS-1:0] mem_rdata;
    logic          flush;
    logic [IS-1:0] instr;
    logic [PS-1:0] instr_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic [PS-1:0] load_val;

    int nvec = 0;
    int nerr = 0;

    instr_fetch #(.Psize(PS), .Isize(IS), .Depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc),
        .pc_incr    (pc_incr),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IS-1:0] rom(input logic [PS-1:0] a);
        return IS'(a) + 20'h100;
    endfunction

    // Program counter: reset to 0, loaded on a taken branch, else incremented on strobe.
    always @(posedge clk) begin
        if (!reset)       pc <= '0;
        else if (flush)   pc <= load_val;
        else if (pc_incr) pc <= pc + 1'b1;
    end

    // Program ROM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= rom(mem_addr);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge, return at the following negedge.
    task automatic tick(input logic r, input logic rdy, input logic fl, input logic [PS-1:0] ld);
        @(posedge clk);
        #1;
        reset       = r;
        instr_ready = rdy;
        flush       = fl;
        load_val    = ld;
        @(negedge clk);
    endtask

    // Reference model: every issued, not yet delivered or discarded word.
    typedef struct {
        logic [PS-1:0] a;
        int            t;
    } ent_t;
    ent_t pend[$];
    int   cyc      = 0;
    bit   armed    = 0;
    bit   zero_exp = 0;
    int   m_cnt;
    int   m_infl;
    bit   m_valid;
    bit   m_pop;
    bit   m_issue;

    always @(negedge clk) begin
        if (armed) begin
            m_cnt  = 0;
            m_infl = 0;
            foreach (pend[i]) begin
                if (pend[i].t <= cyc - 2) m_cnt++;
                if (pend[i].t == cyc - 1) m_infl = 1;
            end
            m_valid = (pend.size() > 0) && (pend[0].t <= cyc - LAT);
            m_pop   = m_valid && instr_ready;
            m_issue = reset && !flush && (m_cnt + m_infl - int'(m_pop) < DEPTH);
            check("model_pc_incr", 32'(pc_incr), 32'(m_issue));
            check("model_mem_en", 32'(mem_en), 32'(m_issue));
            check("model_mem_addr", 32'(mem_addr), 32'(pc));
            check("model_valid", 32'(instr_valid), 32'(m_valid));
            if (m_valid) begin
                check("model_instr_addr", 32'(instr_addr), 32'(pend[0].a));
                check("model_instr", 32'(instr), 32'(rom(pend[0].a)));
                zero_exp = 0;
            end else if (zero_exp) begin
                check("model_reset_instr", 32'(instr), 32'h0);
                check("model_reset_addr", 32'(instr_addr), 32'h0);
            end
            if (m_cnt > DEPTH) check("model_occupancy", 32'(m_cnt), 32'(DEPTH));
            if (!reset || flush) begin
                pend.delete();
            end else begin
                if (m_pop) void'(pend.pop_front());
                if (m_issue) pend.push_back('{a: pc, t: cyc});
            end
        end
        if (!reset) begin
            armed    = 1;
            zero_exp = 1;
            pend.delete();
        end
        cyc++;
    end

    typedef struct {
        logic          ready;
        logic          exp_incr;
        logic          exp_valid;
        logic [PS-1:0] exp_addr;
    } vec_t;

    initial begin
        vec_t          tbl[8];
        logic [PS-1:0] wexp[4];
        logic [PS-1:0] got[4];
        int            k;
        bit            found;

        reset       = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        load_val    = '0;

        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

`ifndef IFETCH_BYPASS_EN
        // Backpressure from reset: two issues, PC holds, then release drains in order.
        tbl[0] = '{1'b0, 1'b1, 1'b0, 6'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 6'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 6'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 6'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 6'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 6'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 6'd2};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 6'd3};
        for (int i = 0; i < 8; i++) begin
            tick(1, tbl[i].ready, 0, 0);
            check($sformatf("tbl%0d_pc_incr", i), 32'(pc_incr), 32'(tbl[i].exp_incr));
            check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_addr", i), 32'(instr_addr), 32'(tbl[i].exp_addr));
                check($sformatf("tbl%0d_instr", i), 32'(instr), 32'(rom(tbl[i].exp_addr)));
            end
        end
`endif

        // Flush mid-stream with a branch to 0x20.
        tick(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
        tick(1, 0, 1, 6'h20);
        tick(1, 1, 0, 0);
        check("flush_valid_cleared", 32'(instr_valid), 32'h0);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            if (instr_valid) begin
                found = 1;
                check("flush_first_addr", 32'(instr_addr), 32'h20);
            end else begin
                tick(1, 1, 0, 0);
            end
        end
        check("flush_resume_found", 32'(found), 32'h1);

        // Address wrap from 0x3F to 0x00 passes through unchanged.
        tick(1, 0, 1, 6'h3E);
        wexp[0] = 6'h3E; wexp[1] = 6'h3F; wexp[2] = 6'h00; wexp[3] = 6'h01;
        k = 0;
        for (int i = 0; i < 12 && k < 4; i++) begin
            tick(1, 1, 0, 0);
            if (instr_valid) begin
                got[k] = instr_addr;
                check($sformatf("wrap%0d_instr", k), 32'(instr), 32'(rom(wexp[k])));
                k++;
            end
        end
        check("wrap_count", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < k) check($sformatf("wrap%0d_addr", i), 32'(got[i]), 32'(wexp[i]));
        end

        // Reset with a full queue, then clean restart.
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        check("full_valid", 32'(instr_valid), 32'h1);
        check("full_pc_hold", 32'(pc_incr), 32'h0);
        tick(0, 0, 0, 0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        tick(0, 1, 0, 0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_addr", 32'(instr_addr), 32'h0);
        check("rst_pc_incr", 32'(pc_incr), 32'h0);
        tick(1, 1, 0, 0);
        check("restart_first_issue", 32'(pc_incr), 32'h1);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick(1, 1, 0, 0);
            if (instr_valid) begin
                found = 1;
                check("restart_first_addr", 32'(instr_addr), 32'h0);
            end
        end
        check("restart_found", 32'(found), 32'h1);

        // Random backpressure with occasional branches.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 39) == 0)
                tick(1, 1'($urandom_range(0, 1)), 1, PS'($urandom_range(0, 63)));
            else
                tick(1, 1'($urandom_range(0, 3) != 0), 0, 0);
        end
        for (int i = 0; i < 6; i++) tick(1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
